quadrature_step_decoder: RTL
============================

// Module: quadrature_step_decoder
// PURPOSE
//  Turns the two raw phases of a mechanical rotary encoder (A/B) into the tick / up_down pair
//  that drives up_down_counter instances (minutes/hours setting on the clock top).
//  Synchronises, debounces and Gray-decodes the phases.
//  Issues one single-cycle tick per detent, with the rotation direction.
// PARAMETERS
//  DEBOUNCE_CYCLES   16  consecutive stable clk cycles before a phase change is accepted (>=1)
//  DB_WIDTH          5   width of debounce counters; must hold DEBOUNCE_CYCLES
//  STEPS_PER_DETENT  4   quadrature sub-steps per detent; legal values 1, 2, 4
// PORTS
//  clk      in   1  system clock, all logic on rising edge
//  reset    in   1  asynchronous, active-low reset
//  enc_a    in   1  raw encoder phase A, asynchronous to clk
//  enc_b    in   1  raw encoder phase B, asynchronous to clk
//  tick     out  1  one-cycle pulse per completed detent
//  up_down  out  1  1 = clockwise / count up, 0 = counter-clockwise / count down; valid with tick, held after
//  err      out  1  one-cycle pulse on an illegal quadrature transition (both phases changed)
// BEHAVIOUR
//  Reset (reset==0, async)
//   - Outputs: tick=0, err=0, up_down=1.
//   - Internal: sync flops=0, filtered AB=00, debounce counters=0, accumulator=0, FSM=S_INIT.
//  Synchroniser
//   - Two flops per phase (s1, s2). A change sampled at edge k is visible in s2 at edge k+1.
//  Debounce, per phase, independent
//   - While s2 != filt, the counter increments each cycle.
//   - The counter clears on any cycle where s2 == filt.
//   - On the edge where the counter reaches DEBOUNCE_CYCLES, filt <= s2 and the counter clears.
//   - Glitches shorter than DEBOUNCE_CYCLES never reach filt.
//  FSM
//   - S_INIT: lasts 3 cycles after reset release. Each cycle filt<=s2 and prev_ab<=s2 directly,
//     with no debounce and no steps, so a resting encoder at 11 or 10 produces no spurious ticks.
//     Then go to S_RUN.
//   - S_RUN: each cycle compare {filt_a,filt_b} with prev_ab, then prev_ab <= {filt_a,filt_b}.
//  Gray decode ({A,B}; CW sequence 00->01->11->10->00)
//   - Unchanged: no action.
//   - CW neighbour: acc <= acc+1.
//   - CCW neighbour: acc <= acc-1.
//   - Both bits changed: err=1 for one cycle, acc <= 0, no tick.
//  Accumulator
//   - Signed, range -STEPS_PER_DETENT..+STEPS_PER_DETENT.
//   - Reversal mid-detent just counts back; no tick.
//   - acc reaches +STEPS_PER_DETENT: next edge tick=1, up_down=1, acc=0.
//   - acc reaches -STEPS_PER_DETENT: next edge tick=1, up_down=0, acc=0.
//  Output registers and latency
//   - tick and err are registered and high for exactly one cycle. tick never fires on consecutive cycles.
//   - up_down changes only on the edge that sets tick.
//   - Latency: phase edge sampled at edge k -> filt changes at edge k+1+DEBOUNCE_CYCLES
//     -> tick (if the detent completes) at edge k+2+DEBOUNCE_CYCLES.
//  Mid-operation reset
//   - A reset mid-operation aborts any pending step and discards partial acc.
//   - After release the module re-enters S_INIT.
// TESTING (DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4 unless noted)
//  1. Reset released with enc_a=1, enc_b=1 held -> tick=0 and err=0 forever; up_down=1.
//  2. CW sequence 00->01->11->10->00, each phase held 10 cycles -> exactly one tick, up_down=1,
//     asserted 6 cycles after the final 10->00 edge is sampled; 4 detents -> 4 ticks.
//  3. CCW sequence 00->10->11->01->00 -> one tick, up_down=0; then one CW detent -> one tick, up_down=1.
//  4. 3 CW sub-steps, then 3 CCW sub-steps (back to 00) -> no tick, no err, acc=0.
//  5. 3-cycle pulse on enc_a from 00 -> no filt change, no tick. Same pulse of 5 cycles -> one sub-step.
//  6. Both phases 00->11 in the same cycle -> err pulse 1 cycle, no tick. Also:
//     reset asserted after 2 CW sub-steps, then 2 more -> no tick. STEPS_PER_DETENT=1: each CW edge ticks.

Source files
------------

// File: rtl/quadrature_step_decoder.sv
// ---------------------------------------------------------------------------
// quadrature_step_decoder
//
// Purpose:
//   Converts the raw A/B phases of a mechanical rotary encoder into a
//   one-cycle tick per detent plus a direction flag. These outputs drive the
//   up_down_counter instances that set minutes and hours. The two phases are
//   synchronised, debounced independently and then Gray-decoded into a
//   signed sub-step accumulator.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-low reset
//   enc_a    in   1  raw encoder phase A (asynchronous to clk)
//   enc_b    in   1  raw encoder phase B (asynchronous to clk)
//   tick     out  1  one-cycle pulse per completed detent
//   up_down  out  1  1 = clockwise / up, 0 = counter-clockwise / down;
//                    updated only together with tick, held afterwards
//   err      out  1  one-cycle pulse when both filtered phases change at once
//
// Interface timing:
//   There is no handshake. tick and err are registered single-cycle
//   strobes, so a consumer must sample them on every clock edge. up_down is
//   valid in the cycle that tick is high and keeps that value until the next
//   tick.
//
// Pipeline and latency:
//   A phase edge that is sampled at clock edge k reaches filt at edge
//   k+1+DEBOUNCE_CYCLES. If that change completes a detent, tick is set at
//   edge k+2+DEBOUNCE_CYCLES.
// ---------------------------------------------------------------------------
module quadrature_step_decoder #(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int DB_WIDTH         = 5,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic tick,
    output logic up_down,
    output logic err
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DB_WIDTH-1:0] DB_LAST   = DB_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]          INIT_LAST = 2'd2;
    localparam logic signed [3:0]   ACC_MAX   = 4'(STEPS_PER_DETENT);

    // In every {A,B} pair below, bit 1 is phase A and bit 0 is phase B.
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] filt;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        init_cnt;
    logic [1:0]        init_cnt_nxt;
    logic [1:0]        prev_ab;
    logic [1:0]        prev_nxt;
    logic signed [3:0] acc;
    logic signed [3:0] acc_nxt;
    logic signed [3:0] acc_step;
    logic              step_cw;
    logic              step_ccw;
    logic              tick_nxt;
    logic              err_nxt;
    logic              up_down_nxt;

    // Clockwise Gray successor: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        case (ab)
            2'b00:   cw_next = 2'b01;
            2'b01:   cw_next = 2'b11;
            2'b11:   cw_next = 2'b10;
            default: cw_next = 2'b00;
        endcase
    endfunction

    // Two-flop synchroniser for both phases.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

    // Per-phase debounce. A phase must differ from filt for DEBOUNCE_CYCLES
    // consecutive cycles before it is accepted. During S_INIT the filter
    // copies the synchronised value directly, so the encoder's resting
    // position is adopted without creating a step.
    for (genvar i = 0; i < 2; i++) begin : g_db
        logic                filt_q;
        logic [DB_WIDTH-1:0] cnt_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                filt_q <= 1'b0;
                cnt_q  <= '0;
            end else if (state == S_INIT) begin
                filt_q <= sync2[i];
                cnt_q  <= '0;
            end else if (sync2[i] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                filt_q <= sync2[i];
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign filt[i] = filt_q;
    end

    assign step_cw  = (filt == cw_next(prev_ab));
    assign step_ccw = (prev_ab == cw_next(filt));

    // Next-state, accumulator and output logic.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        prev_nxt     = prev_ab;
        acc_nxt      = acc;
        acc_step     = acc;
        tick_nxt     = 1'b0;
        err_nxt      = 1'b0;
        up_down_nxt  = up_down;

        case (state)
            S_INIT: begin
                prev_nxt     = sync2;
                acc_nxt      = '0;
                init_cnt_nxt = init_cnt + 2'd1;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                prev_nxt = filt;
                if (step_cw) begin
                    acc_step = acc + 4'sd1;
                end else if (step_ccw) begin
                    acc_step = acc - 4'sd1;
                end

                if (filt != prev_ab && !step_cw && !step_ccw) begin
                    // Both phases moved together, so the direction is unknown.
                    // Drop the partial detent.
                    err_nxt = 1'b1;
                    acc_nxt = '0;
                end else if (!tick && acc_step == ACC_MAX) begin
                    tick_nxt    = 1'b1;
                    up_down_nxt = 1'b1;
                    acc_nxt     = '0;
                end else if (!tick && acc_step == -ACC_MAX) begin
                    tick_nxt    = 1'b1;
                    up_down_nxt = 1'b0;
                    acc_nxt     = '0;
                end else begin
                    // This branch covers ordinary sub-steps. It also covers a
                    // detent that completes while tick is still high: acc then
                    // keeps the full count, and the tick fires on the next
                    // cycle, so two ticks are never back to back.
                    acc_nxt = acc_step;
                end
            end

            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_INIT;
            init_cnt <= 2'd0;
            prev_ab  <= 2'b00;
            acc      <= '0;
            tick     <= 1'b0;
            err      <= 1'b0;
            up_down  <= 1'b1;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
            prev_ab  <= prev_nxt;
            acc      <= acc_nxt;
            tick     <= tick_nxt;
            err      <= err_nxt;
            up_down  <= up_down_nxt;
        end
    end

endmodule
